// File: rtl/reg_file_mp.sv
// Multi-read-port register file: one write port, optional write-to-read bypass,
// and a per-register busy scoreboard with a running count of busy registers.
module reg_file_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_RD    = 2,
    parameter bit          SYNC_READ = 1'b1,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_eff, alloc_eff;

    assign wr_eff    = we && (waddr != '0);
    assign alloc_eff = alloc_en && (alloc_addr != '0);

    // Alloc is applied after the write so a same-address pair leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[waddr] = 1'b0;
        end
        if (alloc_eff) begin
            busy_d[alloc_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (alloc_eff && !busy_q[alloc_addr]) begin
            busy_cnt_d = busy_cnt_d + CNT_ONE;
        end
        if (wr_eff && busy_q[waddr] && !(alloc_eff && (alloc_addr == waddr))) begin
            busy_cnt_d = busy_cnt_d - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_eff) begin
                regs_q[waddr] <= wdata;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;
        logic              rb_val;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // Read sees pre-edge busy state; a same-cycle alloc is never forwarded.
        always_comb begin
            rd_val = regs_q[ra];
            rb_val = busy_q[ra];
            if (ra == '0) begin
                rd_val = '0;
                rb_val = 1'b0;
            end else if (BYPASS && we && (waddr == ra)) begin
                rd_val = wdata;
                rb_val = 1'b0;
            end
        end

        if (SYNC_READ) begin : g_sync
            logic [DATA_W-1:0] rdata_q;
            logic              rbusy_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                    rbusy_q <= 1'b0;
                end else begin
                    rdata_q <= rd_val;
                    rbusy_q <= rb_val;
                end
            end

            assign rdata[k*DATA_W +: DATA_W] = rdata_q;
            assign rbusy[k]                  = rbusy_q;
        end else begin : g_comb
            assign rdata[k*DATA_W +: DATA_W] = rd_val;
            assign rbusy[k]                  = rb_val;
        end
    end

endmodule
